// File: rtl/processador_sysid_pkg.sv
// Shared constants for the system-ID register file: word map, control bits,
// default identification values and the byte-lane merge helper.
package processador_sysid_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_SYSID   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TSTAMP  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_VERSION = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_UP_LO   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_UP_HI   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 3'd7;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_CLR = 1;

  localparam logic [DATA_W-1:0] DEF_SYSTEM_ID = 32'd4919;
  localparam logic [DATA_W-1:0] DEF_TIMESTAMP = 32'd1537363031;
  localparam logic [DATA_W-1:0] DEF_VERSION   = 32'h0001_0000;

  // Replace only the byte lanes selected by be.
  function automatic logic [DATA_W-1:0] apply_be(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/processador_sysid_regs_if.sv
// Avalon-MM slave bus of the system-ID register file (fixed 1-cycle read latency).
interface processador_sysid_regs_if;
  import processador_sysid_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (output address, read, write, writedata, byteenable,
                  input  readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output readdata, readdatavalid);
endinterface

// File: rtl/processador_sysid_uptime.sv
// Free-running uptime counter with enable/clear control and a high-word
// shadow captured whenever the low word is read, so lo/hi pairs are coherent.
module processador_sysid_uptime #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_wr_i,
  input  logic        en_wd_i,
  input  logic        clr_wd_i,
  input  logic        snapshot_i,
  output logic        en_o,
  output logic [31:0] lo_o,
  output logic [31:0] hi_shadow_o
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]      hi_q, hi_d;
  logic                 en_q, en_d;

  // Clear beats increment; increment follows the enable held before this edge.
  always_comb begin
    cnt_d = cnt_q;
    en_d  = en_q;
    hi_d  = hi_q;
    if (ctrl_wr_i && clr_wd_i) cnt_d = '0;
    else if (en_q)             cnt_d = cnt_q + CNT_WIDTH'(1);
    if (ctrl_wr_i)  en_d = en_wd_i;
    if (snapshot_i) hi_d = cnt_q[CNT_WIDTH-1:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
      hi_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      hi_q  <= hi_d;
    end
  end

  assign en_o        = en_q;
  assign lo_o        = cnt_q[31:0];
  assign hi_shadow_o = 32'(hi_q);

endmodule

// File: rtl/processador_sysid_regs.sv
// Eight-word system-ID / uptime / scratch register file on Avalon-MM with a
// heartbeat square-wave output for board-level liveness indication.
module processador_sysid_regs
  import processador_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = DEF_SYSTEM_ID,
  parameter logic [31:0] TIMESTAMP = DEF_TIMESTAMP,
  parameter logic [31:0] VERSION   = DEF_VERSION,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned HB_DIV    = 25_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  processador_sysid_regs_if.slave  avs,
  output logic                     heartbeat
);

  localparam int unsigned DIV_W = $clog2(HB_DIV);

  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rmux;
  logic              rvalid_q, rvalid_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              hb_q, hb_d;
  logic              ctrl_wr, snapshot, en;
  logic [31:0]       up_lo, up_hi;

  assign ctrl_wr  = avs.write && (avs.address == ADDR_CTRL) && avs.byteenable[0];
  assign snapshot = avs.read && (avs.address == ADDR_UP_LO);

  processador_sysid_uptime #(.CNT_WIDTH(CNT_WIDTH)) u_uptime (
    .clock       (clock),
    .reset       (reset),
    .ctrl_wr_i   (ctrl_wr),
    .en_wd_i     (avs.writedata[CTRL_EN]),
    .clr_wd_i    (avs.writedata[CTRL_CLR]),
    .snapshot_i  (snapshot),
    .en_o        (en),
    .lo_o        (up_lo),
    .hi_shadow_o (up_hi)
  );

  // Read mux sees pre-write state, so a simultaneous write is not visible.
  always_comb begin
    rmux = '0;
    case (avs.address)
      ADDR_SYSID:   rmux = SYSTEM_ID;
      ADDR_TSTAMP:  rmux = TIMESTAMP;
      ADDR_VERSION: rmux = VERSION;
      ADDR_UP_LO:   rmux = up_lo;
      ADDR_UP_HI:   rmux = up_hi;
      ADDR_SCRATCH: rmux = scratch_q;
      ADDR_CTRL:    rmux[CTRL_EN] = en;
      default:      rmux = '0;
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    rdata_d   = rdata_q;
    rvalid_d  = avs.read;
    div_d     = div_q + DIV_W'(1);
    hb_d      = hb_q;
    if (avs.write && (avs.address == ADDR_SCRATCH))
      scratch_d = apply_be(scratch_q, avs.writedata, avs.byteenable);
    if (avs.read) rdata_d = rmux;
    if (div_q == DIV_W'(HB_DIV - 1)) begin
      div_d = '0;
      hb_d  = ~hb_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      div_q     <= '0;
      hb_q      <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      div_q     <= div_d;
      hb_q      <= hb_d;
    end
  end

  assign avs.readdata      = rdata_q;
  assign avs.readdatavalid = rvalid_q;
  assign heartbeat         = hb_q;

endmodule

// File: tb/tb_processador_sysid_regs.sv
// Self-checking bench for processador_sysid_regs: directed steps from the test
// plan followed by random traffic, all compared against a behavioural model.
module tb_processador_sysid_regs;

  localparam int unsigned HB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic heartbeat;

  processador_sysid_regs_if bus ();

  processador_sysid_regs #(.HB_DIV(HB)) dut (
    .clock     (clock),
    .reset     (reset),
    .avs       (bus),
    .heartbeat (heartbeat)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_cnt;
  logic [31:0] m_shadow, m_scratch, m_rd;
  logic        m_en, m_rdv;
  int unsigned m_k;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'd4919;
      3'd1:    return 32'd1537363031;
      3'd2:    return 32'h0001_0000;
      3'd3:    return m_cnt[31:0];
      3'd4:    return m_shadow;
      3'd5:    return m_scratch;
      3'd6:    return {31'b0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, update model at posedge, compare 1 time unit later.
  task automatic tick(input logic rst, input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input bit chk);
    logic clr, old_en;
    @(negedge clock);
    reset = rst; bus.read = rd; bus.write = wr; bus.address = a;
    bus.writedata = wd; bus.byteenable = be;
    @(posedge clock);
    if (rst) begin
      m_cnt = '0; m_shadow = '0; m_scratch = '0; m_en = 1'b1;
      m_rdv = 1'b0; m_rd = '0; m_k = 0;
    end else begin
      old_en = m_en;
      clr    = 1'b0;
      if (rd) begin
        m_rd = m_read(a);
        if (a == 3'd3) m_shadow = m_cnt[63:32];
      end
      m_rdv = rd;
      if (wr && a == 3'd5)
        for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
      if (wr && a == 3'd6) begin
        m_en = wd[0];
        clr  = wd[1];
      end
      if (clr)         m_cnt = '0;
      else if (old_en) m_cnt = m_cnt + 64'd1;
      m_k++;
    end
    #1;
    if (chk) begin
      check("readdatavalid", 32'(bus.readdatavalid), 32'(m_rdv));
      check("readdata", bus.readdata, m_rd);
      check("heartbeat", 32'(heartbeat), 32'((m_k / HB) % 2));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
  endtask

  task automatic rd(input logic [2:0] a);
    tick(1'b0, 1'b1, 1'b0, a, 32'd0, 4'h0, 1'b1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    tick(1'b0, 1'b0, 1'b1, a, d, be, 1'b1);
  endtask

  initial begin
    logic [31:0] v;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
    bus.writedata = '0; bus.byteenable = '0;

    tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    check("reset_readdata", bus.readdata, 32'd0);

    // Identification words back-to-back, then reserved
    rd(3'd0); check("sysid", bus.readdata, 32'd4919);
    rd(3'd1); check("timestamp", bus.readdata, 32'd1537363031);
    rd(3'd2); check("version", bus.readdata, 32'h0001_0000);
    rd(3'd7); check("reserved", bus.readdata, 32'd0);
    idle(1);

    wr(3'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(3'd5, 32'h0000_0011, 4'b0001);
    rd(3'd5); check("scratch_be", bus.readdata, 32'hDEAD_BE11);
    wr(3'd0, 32'h1234_5678, 4'b1111);
    rd(3'd0); check("sysid_ro", bus.readdata, 32'd4919);

    // Low-word carry coinciding with a UPTIME_LO read
    @(negedge clock);
    force dut.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 3'd3;
    @(posedge clock); #1;
    check("lo_at_carry", bus.readdata, 32'hFFFF_FFFF);
    release dut.u_uptime.cnt_q;
    @(negedge clock);
    bus.address = 3'd4;
    @(posedge clock); #1;
    check("hi_shadow_at_carry", bus.readdata, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);

    // Counter stop, then clear+enable
    wr(3'd6, 32'd0, 4'hF);
    rd(3'd3); v = bus.readdata;
    idle(9);
    rd(3'd3); check("lo_frozen", bus.readdata, v);
    wr(3'd6, 32'd3, 4'hF);
    rd(3'd3); v = bus.readdata;
    check("lo_small", 32'(v <= 32'd3), 32'd1);
    rd(3'd3); check("lo_increasing", 32'(bus.readdata > v), 32'd1);
    rd(3'd6); check("control_en", bus.readdata, 32'd1);

    // Heartbeat phase and reset in the middle of a high phase
    tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    idle(4); check("hb_first_high", 32'(heartbeat), 32'd1);
    idle(2); check("hb_mid_high", 32'(heartbeat), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    check("hb_after_reset", 32'(heartbeat), 32'd0);

    // Simultaneous read and write of SCRATCH
    wr(3'd5, 32'h0000_000A, 4'hF);
    tick(1'b0, 1'b1, 1'b1, 3'd5, 32'h0000_000B, 4'hF, 1'b1);
    check("rw_old_value", bus.readdata, 32'h0000_000A);
    rd(3'd5); check("rw_new_value", bus.readdata, 32'h0000_000B);

    // Read sampled together with reset is dropped
    tick(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    check("read_with_reset", 32'(bus.readdatavalid), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic        r, w, rs;
      logic [31:0] d;
      logic [3:0]  be;
      a  = 3'($urandom_range(0, 7));
      r  = ($urandom_range(0, 1) == 1);
      w  = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      be = 4'($urandom);
      if (a == 3'd6) begin
        be = 4'hF;
        d  = {30'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)};
      end
      rs = ($urandom_range(0, 63) == 0);
      tick(rs, r, w, a, d, be, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
